p1_maxpool: RTL and testbench
=============================

# p1_maxpool

Layer-1 2×2/stride-2 max-pool stage sitting between the conv1 engine and `p1_data_fifo`. Consumes the conv1 feature map (26×26 pixels, 3 channels, IEEE-754 single per channel) as a raster-order stream and emits the 13×13 pooled map, 3 channels in parallel, in raster order. Its output bus and valid feed `p1_data_fifo` directly, with no backpressure. Each `data_out_valid` pulse writes one FIFO entry.

## Interface
Parameters:
- `IMG_W`, 26, input map width (even)
- `IMG_H`, 26, input map height (even)
- `CH`, 3, channels processed in parallel
- `DW`, 32, bits per channel value (IEEE-754 single)

Ports:
- `clk`  in  1  the single clock; all logic on its rising edge
- `rst_n`  in  1  reset; synchronous, active-high despite the name
- `data_in`  in  CH*DW  conv1 pixel; channel i at `[i*DW +: DW]`
- `data_in_valid`  in  1  `data_in` valid this cycle; gaps allowed anywhere
- `data_out`  out  CH*DW  pooled pixel; channel i at `[i*DW +: DW]`
- `data_out_valid`  out  1  one-cycle pulse per pooled pixel
- `frame_done`  out  1  one-cycle pulse coincident with the 169th (last) `data_out_valid` of a frame

## Operation
- **Counters.** `col` (0..IMG_W-1) and `row` (0..IMG_H-1) advance only on accepted inputs (`data_in_valid`=1).
  - `col` wraps to 0 at IMG_W-1 and increments `row`.
  - `row` wraps to 0 after (IMG_H-1, IMG_W-1), so the next frame starts with no idle cycles required.
- **Float max, per channel.** `fmax(a,b)` is a sign-magnitude compare on raw bits:
  - signs differ: the operand with sign 0 wins;
  - both sign 0: larger `[30:0]` wins;
  - both sign 1: smaller `[30:0]` wins;
  - tie: `a` (the earlier operand) wins.
  - Consequences: +0 beats -0. NaN/Inf get no special handling and are compared as bit patterns.
- **Horizontal stage.**
  - Even `col`: latch the pixel into `hold` (per channel).
  - Odd `col`: `h = fmax(hold, data_in)`.
- **Line buffer.** IMG_W/2 entries × CH*DW bits. Register array or distributed RAM is acceptable.
  - Even `row`, odd `col`: write `h` at index `col>>1`.
  - Odd `row`, odd `col`: read index `col>>1`, then `result = fmax(lb, h)`. The line-buffer value is the first operand.
- **Output register.** `result` is registered into `data_out` with `data_out_valid`=1.
  - `data_out` holds its value between pulses and updates only on a new result.
- **Frame counter.** `out_cnt` (8 bits) counts pulses 0..168.
  - `frame_done` asserts together with the pulse at which `out_cnt`=168; `out_cnt` then wraps to 0.
- **Reset.**
  - `data_out`, `data_out_valid`, `frame_done`, `col`, `row`, `out_cnt` and `hold` all clear to 0.
  - The line buffer is not cleared: every entry is written on an even row before it is read on an odd row.
  - Reset mid-frame discards the partial frame. The next accepted pixel is treated as (row 0, col 0).

## Timing
- Latency: `data_out_valid` asserts exactly 1 cycle after the accepted input at (odd row, odd col).
- Throughput: 1 input per cycle sustained; at most 1 output every 2 cycles.
- Per frame:
  - 676 inputs produce exactly 169 outputs and one `frame_done`;
  - no output during even input rows;
  - 13 outputs during each odd input row.
- `rst_n` high on a cycle: the next edge clears state, and no output pulse follows an input presented in that same cycle.
- Back-to-back frames: the first pixel of frame N+1 may arrive in the cycle right after the last pixel of frame N. The final pulse of frame N and its `frame_done` still appear one cycle later.
- No ready/backpressure input. The downstream FIFO (depth 512) is guaranteed to absorb a full frame.

## Test plan
- **Ramp map.** Channel 0 pixel = float(row*26+col), continuous valid → 169 pulses.
  - Output k (r=k/13, c=k%13) = float((2r+1)*26 + 2c+1). First = 27.0 (0x41D80000); last = 675.0.
  - `frame_done` asserts with pulse 169 only.
- **Sign/zero rules.** One window {-0.0, +0.0, -3.5, -1.0} → +0.0 (0x00000000). Window {-2.0, -5.0, -2.5, -7.0} → -2.0 (0xC0000000).
- **Per-channel independence.** Constant ch0=1.0, ch1=-1.0, ch2 = 2.0 at position (1,1) only, else 0.5.
  - Every output: ch0=1.0, ch1=-1.0.
  - ch2 = 2.0 at output 0, 0.5 elsewhere.
- **Gapped input.** Valid toggles in a random pattern (≥30% idle) over the ramp map → identical 169 values.
  - Each pulse comes exactly 1 cycle after its completing input.
- **Back-to-back frames.** Two ramp frames with no gap → 338 pulses and 2 `frame_done` pulses. Frame 2 values are identical to frame 1.
- **Reset mid-frame.** Assert `rst_n` for 1 cycle after 400 inputs, then send a full ramp frame.
  - Outputs are cleared to 0, with no pulse during or right after reset.
  - The following frame yields the correct 169 outputs with `frame_done` on the last one.

Source files
------------

// File: rtl/p1_maxpool.sv
// p1_maxpool: layer-1 2x2 / stride-2 max-pool over a raster-order feature map.
// Each channel is an IEEE-754 single; the max is a sign-magnitude compare of raw bits.
//
// Ports:
//   clk            - rising-edge clock
//   rst_n          - synchronous reset, active HIGH despite the name
//   data_in        - input pixel, channel i at [i*DW +: DW]
//   data_in_valid  - data_in accepted this cycle
//   data_out       - pooled pixel, channel i at [i*DW +: DW]; holds between pulses
//   data_out_valid - one-cycle pulse per pooled pixel
//   frame_done     - pulses with the last pooled pixel of a frame
module p1_maxpool #(
    parameter int unsigned IMG_W = 26,
    parameter int unsigned IMG_H = 26,
    parameter int unsigned CH    = 3,
    parameter int unsigned DW    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CH*DW-1:0] data_in,
    input  logic             data_in_valid,
    output logic [CH*DW-1:0] data_out,
    output logic             data_out_valid,
    output logic             frame_done
);

    localparam int unsigned BW    = CH * DW;
    localparam int unsigned COL_W = $clog2(IMG_W);
    localparam int unsigned ROW_W = $clog2(IMG_H);
    localparam int unsigned LB_D  = IMG_W / 2;
    localparam int unsigned OUT_N = (IMG_W / 2) * (IMG_H / 2);
    localparam int unsigned OUT_W = 8;

    // Sign-magnitude max on raw float bits; ties keep the first operand.
    function automatic logic [DW-1:0] fmax(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] res;
        res = a;
        if (a[DW-1] != b[DW-1]) begin
            res = a[DW-1] ? b : a;
        end else if (!a[DW-1]) begin
            if (b[DW-2:0] > a[DW-2:0]) res = b;
        end else begin
            if (b[DW-2:0] < a[DW-2:0]) res = b;
        end
        return res;
    endfunction

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic [OUT_W-1:0] r_out_cnt;
    logic [BW-1:0]    r_hold;
    logic [BW-1:0]    r_lb [LB_D];

    logic [COL_W-2:0] w_lb_idx;
    logic [BW-1:0]    w_lb_rd;
    logic [BW-1:0]    w_h;
    logic [BW-1:0]    w_res;
    logic             w_last_col;
    logic             w_last_row;
    logic             w_last_out;

    assign w_lb_idx   = r_col[COL_W-1:1];
    assign w_lb_rd    = r_lb[w_lb_idx];
    assign w_last_col = (r_col == COL_W'(IMG_W - 1));
    assign w_last_row = (r_row == ROW_W'(IMG_H - 1));
    assign w_last_out = (r_out_cnt == OUT_W'(OUT_N - 1));

    // Horizontal max (hold vs current) then vertical max (line buffer vs horizontal).
    for (genvar i = 0; i < CH; i++) begin : g_ch
        assign w_h[i*DW +: DW]   = fmax(r_hold[i*DW +: DW], data_in[i*DW +: DW]);
        assign w_res[i*DW +: DW] = fmax(w_lb_rd[i*DW +: DW], w_h[i*DW +: DW]);
    end

    // Position counters, hold register, output register and frame counter.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_col          <= '0;
            r_row          <= '0;
            r_out_cnt      <= '0;
            r_hold         <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            frame_done     <= 1'b0;
        end else begin
            data_out_valid <= 1'b0;
            frame_done     <= 1'b0;
            if (data_in_valid) begin
                if (w_last_col) begin
                    r_col <= '0;
                    r_row <= w_last_row ? '0 : r_row + ROW_W'(1);
                end else begin
                    r_col <= r_col + COL_W'(1);
                end

                if (!r_col[0]) begin
                    r_hold <= data_in;
                end else if (r_row[0]) begin
                    data_out       <= w_res;
                    data_out_valid <= 1'b1;
                    if (w_last_out) begin
                        frame_done <= 1'b1;
                        r_out_cnt  <= '0;
                    end else begin
                        r_out_cnt  <= r_out_cnt + OUT_W'(1);
                    end
                end
            end
        end
    end

    // Line buffer: even rows write the horizontal max; never cleared, always written before read.
    always_ff @(posedge clk) begin
        if (!rst_n && data_in_valid && r_col[0] && !r_row[0]) begin
            r_lb[w_lb_idx] <= w_h;
        end
    end

endmodule

// File: tb/tb_p1_maxpool.sv
// Testbench for p1_maxpool: scoreboard of expected pooled pixels, checked by a negedge monitor,
// plus per-scenario pulse/frame_done count checks.
module tb_p1_maxpool;

    localparam int unsigned IMG_W = 26;
    localparam int unsigned IMG_H = 26;
    localparam int unsigned CH    = 3;
    localparam int unsigned DW    = 32;
    localparam int unsigned BW    = CH * DW;
    localparam int unsigned NPIX  = IMG_W * IMG_H;
    localparam int unsigned NOUT  = (IMG_W / 2) * (IMG_H / 2);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [BW-1:0] data_in;
    logic          data_in_valid;
    logic [BW-1:0] data_out;
    logic          data_out_valid;
    logic          frame_done;

    int checks = 0;
    int errors = 0;

    bit            mon_en    = 1'b0;
    bit            drv_pulse = 1'b0;
    bit            drv_fd    = 1'b0;
    bit            exp_v     = 1'b0;
    bit            exp_fd    = 1'b0;
    bit            exp_rst   = 1'b0;
    logic [BW-1:0] exp_hold  = '0;
    logic [BW-1:0] sb [$];
    int            pulse_cnt = 0;
    int            fd_cnt    = 0;

    always #5 clk = ~clk;

    p1_maxpool #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CH(CH), .DW(DW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .frame_done     (frame_done)
    );

    // Integer to IEEE-754 single bits (|n| < 2^24).
    function automatic logic [31:0] f32(input int n);
        logic        sgn;
        logic [31:0] mag;
        logic [31:0] sh;
        int          p;
        if (n == 0) return 32'h0;
        sgn = (n < 0);
        mag = sgn ? 32'(-n) : 32'(n);
        p = 0;
        for (int i = 0; i < 31; i++) if (mag[i]) p = i;
        sh = mag << (23 - p);
        return {sgn, 8'(127 + p), 23'(sh)};
    endfunction

    // Stimulus pixel per mode: 0 ramp, 1 sign/zero windows, 2 per-channel.
    function automatic logic [BW-1:0] pixel(input int mode, input int r, input int c);
        logic [31:0] v;
        if (mode == 0) begin
            return {32'h0, f32(-(r * IMG_W + c + 1)), f32(r * IMG_W + c)};
        end else if (mode == 1) begin
            v = 32'h3F800000;
            if (r == 0 && c == 0) v = 32'h80000000;
            if (r == 0 && c == 1) v = 32'h00000000;
            if (r == 1 && c == 0) v = 32'hC0600000;
            if (r == 1 && c == 1) v = 32'hBF800000;
            if (r == 0 && c == 2) v = 32'hC0000000;
            if (r == 0 && c == 3) v = 32'hC0A00000;
            if (r == 1 && c == 2) v = 32'hC0200000;
            if (r == 1 && c == 3) v = 32'hC0E00000;
            return {v, v, v};
        end else begin
            v = (r == 1 && c == 1) ? 32'h40000000 : 32'h3F000000;
            return {v, 32'hBF800000, 32'h3F800000};
        end
    endfunction

    // Expected pooled pixel k for each mode, derived from the stimulus definition.
    function automatic logic [BW-1:0] expected(input int mode, input int k);
        int          r;
        int          c;
        logic [31:0] v;
        r = k / (IMG_W / 2);
        c = k % (IMG_W / 2);
        if (mode == 0) begin
            return {32'h0, f32(-(2 * r * IMG_W + 2 * c + 1)), f32((2 * r + 1) * IMG_W + 2 * c + 1)};
        end else if (mode == 1) begin
            v = (k == 0) ? 32'h00000000 : (k == 1) ? 32'hC0000000 : 32'h3F800000;
            return {v, v, v};
        end else begin
            v = (k == 0) ? 32'h40000000 : 32'h3F000000;
            return {v, 32'hBF800000, 32'h3F800000};
        end
    endfunction

    // Expected-output pipeline: a pixel driven in one cycle produces its pulse after the next edge.
    always @(posedge clk) begin
        exp_v   <= drv_pulse && !rst_n;
        exp_fd  <= drv_fd && !rst_n;
        exp_rst <= rst_n;
    end

    // Monitor: pulse timing, frame_done timing and data_out value (including hold between pulses).
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (data_out_valid !== exp_v) begin
                errors++;
                $display("FAIL valid_timing: got %0b expected %0b at %0t", data_out_valid, exp_v, $time);
            end
            checks++;
            if (frame_done !== exp_fd) begin
                errors++;
                $display("FAIL frame_done: got %0b expected %0b at %0t", frame_done, exp_fd, $time);
            end
            if (exp_rst) begin
                exp_hold = '0;
            end else if (exp_v) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty: pulse with no expected value at %0t", $time);
                end else begin
                    exp_hold = sb.pop_front();
                end
            end
            checks++;
            if (data_out !== exp_hold) begin
                errors++;
                $display("FAIL data_out: got %h expected %h at %0t", data_out, exp_hold, $time);
            end
            if (data_out_valid === 1'b1) pulse_cnt++;
            if (frame_done === 1'b1) fd_cnt++;
        end
    end

    task automatic drive(input logic [BW-1:0] d, input bit v, input bit pulse, input bit fd,
                         input logic [BW-1:0] e);
        @(posedge clk);
        #1;
        data_in       = d;
        data_in_valid = v;
        drv_pulse     = pulse;
        drv_fd        = fd;
        if (pulse) sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive('0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    // Sends the first n raster pixels of a frame; gap is the per-slot idle probability in percent.
    task automatic send_pixels(input int mode, input int gap, input int n);
        for (int idx = 0; idx < n; idx++) begin
            int r;
            int c;
            bit comp;
            bit fd;
            r = idx / IMG_W;
            c = idx % IMG_W;
            if (gap > 0)
                for (int g = 0; g < 8 && $urandom_range(0, 99) < 32'(gap); g++) idle(1);
            comp = (r % 2 == 1) && (c % 2 == 1);
            fd   = comp && (r == IMG_H - 1) && (c == IMG_W - 1);
            drive(pixel(mode, r, c), 1'b1, comp, fd,
                  comp ? expected(mode, (r / 2) * (IMG_W / 2) + c / 2) : '0);
        end
    endtask

    task automatic check_counts(input string name, input int p0, input int f0,
                                input int pe, input int fe);
        checks++;
        if (pulse_cnt - p0 != pe) begin
            errors++;
            $display("FAIL %s_pulses: got %0d expected %0d", name, pulse_cnt - p0, pe);
        end
        checks++;
        if (fd_cnt - f0 != fe) begin
            errors++;
            $display("FAIL %s_frame_done: got %0d expected %0d", name, fd_cnt - f0, fe);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_leftover: got %0d expected 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b1;
        data_in       = '0;
        data_in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (data_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %0b expected 0", data_out_valid);
        end
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_frame_done: got %0b expected 0", frame_done);
        end
        checks++;
        if (data_out !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h expected 0", data_out);
        end
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
    endtask

    task automatic test_ramp();
        int p0 = pulse_cnt;
        int f0 = fd_cnt;
        send_pixels(0, 0, NPIX);
        idle(3);
        check_counts("ramp", p0, f0, NOUT, 1);
        checks++;
        if (data_out[31:0] !== 32'h4428C000) begin
            errors++;
            $display("FAIL ramp_last_value: got %h expected 4428c000", data_out[31:0]);
        end
    endtask

    task automatic test_sign_zero();
        int p0 = pulse_cnt;
        int f0 = fd_cnt;
        send_pixels(1, 0, NPIX);
        idle(3);
        check_counts("sign_zero", p0, f0, NOUT, 1);
    endtask

    task automatic test_channels();
        int p0 = pulse_cnt;
        int f0 = fd_cnt;
        send_pixels(2, 0, NPIX);
        idle(3);
        check_counts("channels", p0, f0, NOUT, 1);
    endtask

    task automatic test_gapped();
        int p0 = pulse_cnt;
        int f0 = fd_cnt;
        send_pixels(0, 45, NPIX);
        idle(3);
        check_counts("gapped", p0, f0, NOUT, 1);
    endtask

    task automatic test_back_to_back();
        int p0 = pulse_cnt;
        int f0 = fd_cnt;
        send_pixels(0, 0, NPIX);
        send_pixels(0, 0, NPIX);
        idle(3);
        check_counts("back_to_back", p0, f0, 2 * NOUT, 2);
    endtask

    task automatic test_reset_mid_frame();
        int p0;
        int f0;
        send_pixels(0, 0, 400);
        // Reset cycle with a valid input present; it must not produce a pulse.
        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        data_in       = pixel(0, 15, 10);
        data_in_valid = 1'b1;
        drv_pulse     = 1'b0;
        drv_fd        = 1'b0;
        @(posedge clk);
        #1;
        rst_n         = 1'b0;
        data_in_valid = 1'b0;
        checks++;
        if (data_out !== '0 || data_out_valid !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_clear: got data %h valid %0b done %0b expected all 0",
                     data_out, data_out_valid, frame_done);
        end
        idle(2);
        p0 = pulse_cnt;
        f0 = fd_cnt;
        send_pixels(0, 0, NPIX);
        idle(3);
        check_counts("after_reset", p0, f0, NOUT, 1);
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_sign_zero();
        test_channels();
        test_gapped();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
